csr_ctrl: RTL and testbench
===========================

// Module: csr_ctrl
// PURPOSE
//  Machine-mode CSR controller wrapping the CSR write-data datapath. It owns mstatus, mtvec,
//  mepc and mcause. It sequences CSR instructions as a 2-cycle read-modify-write, and
//  sequences ecall/mret traps with a one-pulse PC redirect. It sits in the EXU beside the ALU.
// PARAMETERS
//  MSTATUS_RST  32'h0000_1800  mstatus reset value (MPP=M)
//  MTVEC_RST    32'h0000_0000  mtvec reset value; bits[1:0] forced 0
//  ECALL_CAUSE  32'd11         mcause value written on ecall (ECALL from M)
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   synchronous active-low reset
//  req_valid       in   1   request present
//  req_ready       out  1   1 only in IDLE
//  csr_op          in   6   one-hot: [0]rw [1]rs [2]rc [3]rwi [4]rsi [5]rci; all-0 = no CSR op
//  csr_addr        in   12  CSR address
//  rf_rdata        in   32  rs1 value (register variants)
//  zimm            in   5   immediate; zero-extended to 32 (immediate variants)
//  ecall           in   1   ecall request
//  mret            in   1   mret request
//  pc              in   32  PC of the requesting instruction
//  resp_valid      out  1   1-cycle pulse: CSR op complete
//  resp_rdata      out  32  old CSR value (to rd); valid with resp_valid
//  illegal         out  1   with resp_valid: bad address or non-one-hot csr_op; no write
//  redirect_valid  out  1   1-cycle pulse: fetch must jump
//  redirect_pc     out  32  target PC; valid with redirect_valid
// BEHAVIOUR
//  - Address map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause. Any other address is illegal.
//  - FSM states: IDLE, READ, WRITE, TRAP.
//  - Accept rule: a request is accepted when req_valid && req_ready. Inputs are latched on accept.
//    Accept priority: ecall > mret > CSR op. A request with none of the three completes nothing.
//  - CSR op timing:
//    - IDLE->READ on accept. READ latches the old CSR value.
//    - READ->WRITE. WRITE computes wdata: rw=src, rs=old|src, rc=old&~src.
//      src is rf_rdata for variants 0-2 and {27'b0,zimm} for variants 3-5.
//    - WRITE commits on the clock edge, pulses resp_valid and resp_rdata=old, then returns to IDLE.
//    - Latency: resp_valid is seen 2 cycles after the accept edge. Throughput: 1 op per 3 cycles.
//  - Write suppression:
//    - rsi/rci with zimm==0: no write, but resp_valid and resp_rdata are still produced.
//    - Illegal: no write; resp_valid=1, illegal=1, resp_rdata=0.
//  - Write masking: mtvec and mepc writes force bits[1:0]=0. mstatus writes only MIE[3], MPIE[7]
//    and MPP[12:11]; other bits read 0 except MPP, which holds its written value.
//  - ecall: IDLE->TRAP. On the TRAP edge:
//    - mepc<=pc, mcause<=ECALL_CAUSE, MPIE<=MIE, MIE<=0, MPP<=2'b11.
//    - redirect_valid=1 with redirect_pc=mtvec (value before this edge); then IDLE.
//  - mret: IDLE->TRAP. On the TRAP edge:
//    - MIE<=MPIE, MPIE<=1.
//    - redirect_valid=1 with redirect_pc=mepc; then IDLE.
//  - Simultaneous ecall+mret: ecall wins; mret is dropped.
//    Simultaneous csr_op+ecall: trap only, no CSR write.
//  - Reset: state=IDLE, req_ready=0 during reset; all other outputs 0; CSRs take reset values.
//    rst_n low mid-operation aborts with no CSR write and no pulse.
//  - resp_valid and redirect_valid are never both 1.
// CONFIGURATION
//  CSR_MSCRATCH_EN defined: adds mscratch at 0x340 (32-bit, fully writable, reset 0),
//    with the same RMW timing as the other CSRs.
//  CSR_MSCRATCH_EN undefined: 0x340 is illegal like any unmapped address.
// TESTING
//  1. Reset then csrrw 0x305 with rf_rdata=32'h8000_0103
//     -> resp at accept+2, resp_rdata=0; later read of mtvec=32'h8000_0100.
//  2. csrrs 0x300 with rf_rdata=8 (MIE=1), then ecall with pc=32'h8000_0040
//     -> redirect_pc=mtvec, mepc=32'h8000_0040, mcause=11, mstatus=32'h0000_1880.
//  3. mret after test 2 -> redirect_pc=32'h8000_0040, mstatus=32'h0000_1888.
//  4. csrrci 0x342 with zimm=0 -> resp_rdata=11, mcause unchanged;
//     csr_op=6'b000011 -> illegal=1, no write.
//  5. csrrw 0x340 with rf_rdata=32'hDEAD_BEEF
//     -> CSR_MSCRATCH_EN defined: readback DEAD_BEEF; undefined: illegal=1.
//  6. rst_n low in WRITE cycle of a csrrw to mepc -> no resp_valid, mepc=0, req_ready=1 after release.

Source files
------------

// File: rtl/csr_ctrl.sv
// Machine-mode CSR controller: 2-cycle RMW for CSR ops, ecall/mret trap redirect.
// Optional mscratch at 0x340 when CSR_MSCRATCH_EN is defined.
module csr_ctrl #(
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_csr_op,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_rf_rdata,
  input  logic [4:0]  i_zimm,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic [31:0] i_pc,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_illegal,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_TRAP
  } state_t;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;

  state_t r_state;
  state_t w_next;

  logic [5:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_rs;
  logic [4:0]  r_zimm;
  logic [31:0] r_pc;
  logic        r_ecall;
  logic [31:0] r_old;

  logic        r_mie;
  logic        r_mpie;
  logic [1:0]  r_mpp;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
`ifdef CSR_MSCRATCH_EN
  logic [31:0] r_mscratch;
`endif

  logic        w_accept;
  logic        w_onehot;
  logic        w_addr_ok;
  logic        w_illegal;
  logic [31:0] w_mstatus;
  logic [31:0] w_rd;
  logic [31:0] w_src;
  logic [31:0] w_wdata;
  logic        w_wen;

  assign o_req_ready = (r_state == S_IDLE) && i_rst_n;
  assign w_accept    = i_req_valid && o_req_ready;

  assign w_mstatus = {19'b0, r_mpp, 3'b0, r_mpie,
                      3'b0, r_mie, 3'b0};

  assign w_onehot = (r_op != 6'd0) &&
                    ((r_op & (r_op - 6'd1)) == 6'd0);

  always_comb begin
    w_addr_ok = 1'b1;
    w_rd      = 32'd0;
    case (r_addr)
      A_MSTATUS:  w_rd = w_mstatus;
      A_MTVEC:    w_rd = r_mtvec;
      A_MEPC:     w_rd = r_mepc;
      A_MCAUSE:   w_rd = r_mcause;
`ifdef CSR_MSCRATCH_EN
      A_MSCRATCH: w_rd = r_mscratch;
`endif
      default:    w_addr_ok = 1'b0;
    endcase
  end

  assign w_illegal = !w_onehot || !w_addr_ok;
  assign w_src = (|r_op[5:3]) ? {27'b0, r_zimm} : r_rs;

  // Op decode is safe for multi-hot codes: those are illegal and never write.
  always_comb begin
    w_wdata = r_old;
    if (r_op[0] || r_op[3])
      w_wdata = w_src;
    else if (r_op[1] || r_op[4])
      w_wdata = r_old | w_src;
    else if (r_op[2] || r_op[5])
      w_wdata = r_old & ~w_src;
  end

  assign w_wen = (r_state == S_WRITE) && !w_illegal &&
                 !((r_op[4] || r_op[5]) && (r_zimm == 5'd0));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_ecall || i_mret)
            w_next = S_TRAP;
          else if (|i_csr_op)
            w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      S_TRAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op             <= '0;
      r_addr           <= '0;
      r_rs             <= '0;
      r_zimm           <= '0;
      r_pc             <= '0;
      r_ecall          <= 1'b0;
      r_old            <= '0;
      r_mie            <= MSTATUS_RST[3];
      r_mpie           <= MSTATUS_RST[7];
      r_mpp            <= MSTATUS_RST[12:11];
      r_mtvec          <= {MTVEC_RST[31:2], 2'b00};
      r_mepc           <= '0;
      r_mcause         <= '0;
`ifdef CSR_MSCRATCH_EN
      r_mscratch       <= '0;
`endif
      o_resp_valid     <= 1'b0;
      o_resp_rdata     <= '0;
      o_illegal        <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      o_resp_valid     <= 1'b0;
      o_resp_rdata     <= '0;
      o_illegal        <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      if (w_accept) begin
        r_op    <= i_csr_op;
        r_addr  <= i_csr_addr;
        r_rs    <= i_rf_rdata;
        r_zimm  <= i_zimm;
        r_pc    <= i_pc;
        r_ecall <= i_ecall;
      end
      if (r_state == S_READ)
        r_old <= w_rd;
      if (r_state == S_WRITE) begin
        o_resp_valid <= 1'b1;
        o_resp_rdata <= w_illegal ? 32'd0 : r_old;
        o_illegal    <= w_illegal;
      end
      if (w_wen) begin
        case (r_addr)
          A_MSTATUS: begin
            r_mie  <= w_wdata[3];
            r_mpie <= w_wdata[7];
            r_mpp  <= w_wdata[12:11];
          end
          A_MTVEC:    r_mtvec    <= {w_wdata[31:2], 2'b00};
          A_MEPC:     r_mepc     <= {w_wdata[31:2], 2'b00};
          A_MCAUSE:   r_mcause   <= w_wdata;
`ifdef CSR_MSCRATCH_EN
          A_MSCRATCH: r_mscratch <= w_wdata;
`endif
          default: ;
        endcase
      end
      // Redirect target is sampled before this edge's CSR updates.
      if (r_state == S_TRAP) begin
        o_redirect_valid <= 1'b1;
        if (r_ecall) begin
          o_redirect_pc <= r_mtvec;
          r_mepc        <= r_pc;
          r_mcause      <= ECALL_CAUSE;
          r_mpie        <= r_mie;
          r_mie         <= 1'b0;
          r_mpp         <= 2'b11;
        end else begin
          o_redirect_pc <= r_mepc;
          r_mie         <= r_mpie;
          r_mpie        <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed vector bench for csr_ctrl: RMW latency, masking, traps, reset abort.
// Honours CSR_MSCRATCH_EN for the 0x340 expectations.
module tb_csr_ctrl;

  localparam logic [5:0] RW  = 6'b000001;
  localparam logic [5:0] RS  = 6'b000010;
  localparam logic [5:0] RC  = 6'b000100;
  localparam logic [5:0] RWI = 6'b001000;
  localparam logic [5:0] RSI = 6'b010000;
  localparam logic [5:0] RCI = 6'b100000;
  localparam int K_NONE = 0;
  localparam int K_RESP = 1;
  localparam int K_RDR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] rf_rdata = '0;
  logic [4:0]  zimm = '0;
  logic        ecall = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] pc = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_csr_op         (csr_op),
    .i_csr_addr       (csr_addr),
    .i_rf_rdata       (rf_rdata),
    .i_zimm           (zimm),
    .i_ecall          (ecall),
    .i_mret           (mret),
    .i_pc             (pc),
    .o_resp_valid     (resp_valid),
    .o_resp_rdata     (resp_rdata),
    .o_illegal        (illegal),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [5:0]  op;
    logic [11:0] addr;
    logic [31:0] rs;
    logic [4:0]  z;
    logic        ec;
    logic        mr;
    logic [31:0] pc;
    int          kind;
    logic [31:0] data;
    logic        ill;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic [5:0] op, logic [11:0] a, logic [31:0] rs,
    logic [4:0] z, logic ec, logic mr, logic [31:0] p,
    int kind, logic [31:0] d, logic ill);
    vec_t v;
    v.op = op; v.addr = a; v.rs = rs; v.z = z;
    v.ec = ec; v.mr = mr; v.pc = p;
    v.kind = kind; v.data = d; v.ill = ill;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    csr_op = '0; csr_addr = '0; rf_rdata = '0;
    zimm = '0; ecall = 1'b0; mret = 1'b0; pc = '0;
  endtask

  task automatic run(input vec_t v, input int idx);
    int w;
    int kind;
    int lat;
    int pulses;
    logic [31:0] d;
    logic ill;
    logic rdy;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    csr_op = v.op; csr_addr = v.addr; rf_rdata = v.rs;
    zimm = v.z; ecall = v.ec; mret = v.mr; pc = v.pc;
    @(posedge clk);
    #1 idle_in();
    kind = K_NONE; lat = 0; pulses = 0;
    d = '0; ill = 1'b0; rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (resp_valid && redirect_valid) pulses += 10;
      if (resp_valid || redirect_valid) begin
        pulses++;
        if (kind == K_NONE) begin
          kind = resp_valid ? K_RESP : K_RDR;
          lat  = k - 1;
          d    = resp_valid ? resp_rdata : redirect_pc;
          ill  = illegal;
          rdy  = req_ready;
        end
      end
    end
    chk($sformatf("v%0d kind", idx), kind, v.kind);
    if (v.kind != K_NONE) begin
      chk($sformatf("v%0d latency", idx), lat,
          (v.kind == K_RESP) ? 2 : 1);
      chk($sformatf("v%0d data", idx), d, v.data);
      chk($sformatf("v%0d pulses", idx), pulses, 1);
    end
    if (v.kind == K_RESP) begin
      chk($sformatf("v%0d illegal", idx), {31'b0, ill},
          {31'b0, v.ill});
      chk($sformatf("v%0d ready_at_resp", idx),
          {31'b0, rdy}, 32'd1);
    end
  endtask

  initial begin
    tv.push_back(mk(RW, 12'h305, 32'h8000_0103, 0, 0, 0, 0, K_RESP, 32'h0, 0));
    tv.push_back(mk(RS, 12'h305, 0, 0, 0, 0, 0, K_RESP, 32'h8000_0100, 0));
    tv.push_back(mk(RS, 12'h300, 8, 0, 0, 0, 0, K_RESP, 32'h1800, 0));
    tv.push_back(mk(RW, 12'h305, 32'hFFFF_FFFF, 0, 1, 0, 32'h8000_0040, K_RDR, 32'h8000_0100, 0));
    tv.push_back(mk(RS, 12'h305, 0, 0, 0, 0, 0, K_RESP, 32'h8000_0100, 0));
    tv.push_back(mk(RS, 12'h341, 0, 0, 0, 0, 0, K_RESP, 32'h8000_0040, 0));
    tv.push_back(mk(RS, 12'h342, 0, 0, 0, 0, 0, K_RESP, 32'd11, 0));
    tv.push_back(mk(RS, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h1880, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, K_RDR, 32'h8000_0040, 0));
    tv.push_back(mk(RS, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h1888, 0));
    tv.push_back(mk(RCI, 12'h342, 0, 0, 0, 0, 0, K_RESP, 32'd11, 0));
    tv.push_back(mk(RS, 12'h342, 0, 0, 0, 0, 0, K_RESP, 32'd11, 0));
    tv.push_back(mk(6'b000011, 12'h342, 32'hFFFF_FFFF, 0, 0, 0, 0, K_RESP, 32'h0, 1));
    tv.push_back(mk(RS, 12'h342, 0, 0, 0, 0, 0, K_RESP, 32'd11, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 32'h8000_0044, K_RDR, 32'h8000_0100, 0));
    tv.push_back(mk(RS, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h1880, 0));
    tv.push_back(mk(RS, 12'h341, 0, 0, 0, 0, 0, K_RESP, 32'h8000_0044, 0));
`ifdef CSR_MSCRATCH_EN
    tv.push_back(mk(RW, 12'h340, 32'hDEAD_BEEF, 0, 0, 0, 0, K_RESP, 32'h0, 0));
    tv.push_back(mk(RS, 12'h340, 0, 0, 0, 0, 0, K_RESP, 32'hDEAD_BEEF, 0));
`else
    tv.push_back(mk(RW, 12'h340, 32'hDEAD_BEEF, 0, 0, 0, 0, K_RESP, 32'h0, 1));
    tv.push_back(mk(RS, 12'h340, 0, 0, 0, 0, 0, K_RESP, 32'h0, 1));
`endif
    tv.push_back(mk(RW, 12'h300, 32'hFFFF_FFFF, 0, 0, 0, 0, K_RESP, 32'h1880, 0));
    tv.push_back(mk(RS, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h1888, 0));
    tv.push_back(mk(RWI, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h1888, 0));
    tv.push_back(mk(RS, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h0, 0));
    tv.push_back(mk(RSI, 12'h305, 0, 5'd7, 0, 0, 0, K_RESP, 32'h8000_0100, 0));
    tv.push_back(mk(RCI, 12'h305, 0, 5'd4, 0, 0, 0, K_RESP, 32'h8000_0104, 0));
    tv.push_back(mk(RS, 12'h305, 0, 0, 0, 0, 0, K_RESP, 32'h8000_0100, 0));
    tv.push_back(mk(RC, 12'h341, 32'h8000_0000, 0, 0, 0, 0, K_RESP, 32'h8000_0044, 0));
    tv.push_back(mk(RS, 12'h341, 0, 0, 0, 0, 0, K_RESP, 32'h0000_0044, 0));
    tv.push_back(mk(RW, 12'h301, 1, 0, 0, 0, 0, K_RESP, 32'h0, 1));
    tv.push_back(mk(0, 12'h300, 0, 0, 0, 0, 0, K_NONE, 32'h0, 0));
    tv.push_back(mk(RSI, 12'h342, 0, 0, 0, 0, 0, K_RESP, 32'd11, 0));
    tv.push_back(mk(RS, 12'h342, 0, 0, 0, 0, 0, K_RESP, 32'd11, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, K_RDR, 32'h0000_0044, 0));
    tv.push_back(mk(RS, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h0000_0080, 0));

    idle_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'b0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    chk("rst illegal", {31'b0, illegal}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      run(tv[i], i);

    // Reset asserted during the WRITE cycle of a csrrw to mepc.
    @(negedge clk);
    req_valid = 1'b1;
    csr_op = RW; csr_addr = 12'h341; rf_rdata = 32'h1234_5678;
    @(posedge clk);
    #1 idle_in();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort ready_in_rst", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort resp_valid2", {31'b0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    #1 chk("abort ready_after", {31'b0, req_ready}, 32'd1);

    run(mk(RS, 12'h341, 0, 0, 0, 0, 0, K_RESP, 32'h0, 0), 100);
    run(mk(RS, 12'h300, 0, 0, 0, 0, 0, K_RESP, 32'h1800, 0), 101);
    run(mk(RS, 12'h305, 0, 0, 0, 0, 0, K_RESP, 32'h0, 0), 102);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
